// File: rtl/chirp_pkg.sv
// Shared types and widths for the chirp control path and the DDS block it feeds.
package chirp_pkg;

    localparam int PHI_W  = 48;
    localparam int RATE_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HS_HI = 3'd1,
        ST_HS_LO = 3'd2,
        ST_ARM   = 3'd3,
        ST_PULSE = 3'd4,
        ST_GAP   = 3'd5
    } seq_state_t;

    typedef struct packed {
        logic [PHI_W-1:0]  freq;
        logic [PHI_W-1:0]  delta_freq;
        logic [RATE_W-1:0] delta_rate;
    } chirp_cfg_t;

endpackage

// File: rtl/req_ack_tx.sv
// Four-phase REQ/ACK sender with a per-edge timeout on the ACK waits.
module req_ack_tx #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic send,
    input  logic ack,
    output logic req,
    output logic hi_done,
    output logic lo_done,
    output logic timeout
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_HI   = 2'd1;
    localparam logic [1:0] TX_LO   = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            req_q, req_d;

    // Handshake: REQ rises after send, falls once ACK is seen high; the
    // transfer is complete when ACK is then seen low. Each wait is bounded.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        hi_done = 1'b0;
        lo_done = 1'b0;
        timeout = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (send) begin
                    state_d = TX_HI;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            TX_HI: begin
                if (ack) begin
                    hi_done = 1'b1;
                    req_d   = 1'b0;
                    state_d = TX_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    timeout = 1'b1;
                    req_d   = 1'b0;
                    state_d = TX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TX_LO: begin
                if (!ack) begin
                    lo_done = 1'b1;
                    state_d = TX_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout = 1'b1;
                    state_d = TX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = TX_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    assign req = req_q;

endmodule

// File: rtl/chirp_pulse_sequencer.sv
// Captures a chirp configuration, hands it to the DDS over REQ/ACK, then
// gates the DDS with a burst of programmable-length, programmable-period pulses.
module chirp_pulse_sequencer
    import chirp_pkg::*;
#(
    parameter int HS_TIMEOUT = 1024,
    parameter int MIN_GAP    = 2,
    parameter int CNT_W      = 32
) (
    input  logic              clk_48,
    input  logic              rst,
    input  logic              cfg_wr,
    input  logic [PHI_W-1:0]  cfg_freq,
    input  logic [PHI_W-1:0]  cfg_delta_freq,
    input  logic [RATE_W-1:0] cfg_delta_rate,
    input  logic [CNT_W-1:0]  cfg_pulse_len,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [15:0]       cfg_count,
    input  logic              run,
    input  logic              ACK,
    output logic              REQ,
    output logic [PHI_W-1:0]  DDS_freq,
    output logic [PHI_W-1:0]  DDS_delta_freq,
    output logic [RATE_W-1:0] DDS_delta_rate,
    output logic              start,
    output logic              busy,
    output logic              seq_done,
    output logic              cfg_ignored,
    output logic              hs_err
);

    seq_state_t       state_q, state_d;
    chirp_cfg_t       cfg_q, cfg_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [15:0]      count_q, count_d;
    logic [15:0]      burst_q, burst_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic             start_q, start_d;
    logic             run_prev_q, run_prev_d;
    logic             seq_done_q, seq_done_d;
    logic             cfg_ign_q, cfg_ign_d;
    logic             hs_err_q, hs_err_d;

    logic             idle_or_arm;
    logic             accept;
    logic             run_rise;
    logic [CNT_W-1:0] len_w;
    logic [CNT_W-1:0] len_m1;
    logic [CNT_W-1:0] gap_m1;
    logic             hs_hi_done, hs_lo_done, hs_timeout;

    assign idle_or_arm = (state_q == ST_IDLE) || (state_q == ST_ARM);
    assign accept      = cfg_wr && idle_or_arm;
    assign run_rise    = run && !run_prev_q;

    // A zero pulse length still produces a one-cycle pulse. The gap compare is
    // one bit wider so len + MIN_GAP cannot wrap and hide a too-short period.
    always_comb begin
        len_w  = (len_q == '0) ? CNT_W'(1) : len_q;
        len_m1 = len_w - 1'b1;
        if ({1'b0, period_q} >= ({1'b0, len_w} + (CNT_W + 1)'(MIN_GAP))) begin
            gap_m1 = period_q - len_w - 1'b1;
        end else begin
            gap_m1 = CNT_W'(MIN_GAP - 1);
        end
    end

    req_ack_tx #(
        .TIMEOUT(HS_TIMEOUT)
    ) u_hs (
        .clk     (clk_48),
        .rst     (rst),
        .send    (accept),
        .ack     (ACK),
        .req     (REQ),
        .hi_done (hs_hi_done),
        .lo_done (hs_lo_done),
        .timeout (hs_timeout)
    );

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        len_d      = len_q;
        period_d   = period_q;
        count_d    = count_q;
        burst_d    = burst_q;
        pcnt_d     = pcnt_q;
        start_d    = start_q;
        run_prev_d = run;
        seq_done_d = 1'b0;
        cfg_ign_d  = cfg_wr && !idle_or_arm;
        hs_err_d   = hs_err_q;

        if (accept) begin
            cfg_d.freq       = cfg_freq;
            cfg_d.delta_freq = cfg_delta_freq;
            cfg_d.delta_rate = cfg_delta_rate;
            len_d            = cfg_pulse_len;
            period_d         = cfg_period;
            count_d          = cfg_count;
            hs_err_d         = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_HS_HI;
            end
            ST_ARM: begin
                // A configuration write takes priority over a run edge.
                if (accept) begin
                    state_d = ST_HS_HI;
                end else if (run_rise) begin
                    state_d = ST_PULSE;
                    start_d = 1'b1;
                    pcnt_d  = '0;
                    burst_d = count_q;
                end
            end
            ST_HS_HI: begin
                if (hs_timeout) begin
                    state_d  = ST_IDLE;
                    hs_err_d = 1'b1;
                end else if (hs_hi_done) begin
                    state_d = ST_HS_LO;
                end
            end
            ST_HS_LO: begin
                if (hs_timeout) begin
                    state_d  = ST_IDLE;
                    hs_err_d = 1'b1;
                end else if (hs_lo_done) begin
                    state_d = ST_ARM;
                end
            end
            ST_PULSE: begin
                if (!run) begin
                    state_d = ST_ARM;
                    start_d = 1'b0;
                end else if (pcnt_q == len_m1) begin
                    start_d = 1'b0;
                    pcnt_d  = '0;
                    if (count_q != 16'd0) burst_d = burst_q - 1'b1;
                    if ((count_q != 16'd0) && (burst_q == 16'd1)) begin
                        state_d    = ST_ARM;
                        seq_done_d = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (!run) begin
                    state_d = ST_ARM;
                end else if (pcnt_q == gap_m1) begin
                    state_d = ST_PULSE;
                    start_d = 1'b1;
                    pcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                start_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_48 or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cfg_q      <= '0;
            len_q      <= '0;
            period_q   <= '0;
            count_q    <= '0;
            burst_q    <= '0;
            pcnt_q     <= '0;
            start_q    <= 1'b0;
            run_prev_q <= 1'b0;
            seq_done_q <= 1'b0;
            cfg_ign_q  <= 1'b0;
            hs_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            len_q      <= len_d;
            period_q   <= period_d;
            count_q    <= count_d;
            burst_q    <= burst_d;
            pcnt_q     <= pcnt_d;
            start_q    <= start_d;
            run_prev_q <= run_prev_d;
            seq_done_q <= seq_done_d;
            cfg_ign_q  <= cfg_ign_d;
            hs_err_q   <= hs_err_d;
        end
    end

    assign DDS_freq       = cfg_q.freq;
    assign DDS_delta_freq = cfg_q.delta_freq;
    assign DDS_delta_rate = cfg_q.delta_rate;
    assign start          = start_q;
    assign busy           = !idle_or_arm;
    assign seq_done       = seq_done_q;
    assign cfg_ignored    = cfg_ign_q;
    assign hs_err         = hs_err_q;

endmodule

// File: tb/tb_chirp_pulse_sequencer.sv
// Directed bench for chirp_pulse_sequencer: handshake, burst timing, gap clamp,
// handshake timeout, abort/ignore behaviour and asynchronous reset.
module tb_chirp_pulse_sequencer;

    logic        clk_48 = 1'b0;
    logic        rst;
    logic        cfg_wr;
    logic [47:0] cfg_freq;
    logic [47:0] cfg_delta_freq;
    logic [31:0] cfg_delta_rate;
    logic [31:0] cfg_pulse_len;
    logic [31:0] cfg_period;
    logic [15:0] cfg_count;
    logic        run;
    logic        ACK;
    logic        REQ;
    logic [47:0] DDS_freq;
    logic [47:0] DDS_delta_freq;
    logic [31:0] DDS_delta_rate;
    logic        start;
    logic        busy;
    logic        seq_done;
    logic        cfg_ignored;
    logic        hs_err;

    int n_chk  = 0;
    int n_fail = 0;
    int rise_q[$];
    int plen_q[$];
    int done_q[$];

    always #5 clk_48 = ~clk_48;

    chirp_pulse_sequencer #(
        .HS_TIMEOUT (1024),
        .MIN_GAP    (2),
        .CNT_W      (32)
    ) dut (
        .clk_48         (clk_48),
        .rst            (rst),
        .cfg_wr         (cfg_wr),
        .cfg_freq       (cfg_freq),
        .cfg_delta_freq (cfg_delta_freq),
        .cfg_delta_rate (cfg_delta_rate),
        .cfg_pulse_len  (cfg_pulse_len),
        .cfg_period     (cfg_period),
        .cfg_count      (cfg_count),
        .run            (run),
        .ACK            (ACK),
        .REQ            (REQ),
        .DDS_freq       (DDS_freq),
        .DDS_delta_freq (DDS_delta_freq),
        .DDS_delta_rate (DDS_delta_rate),
        .start          (start),
        .busy           (busy),
        .seq_done       (seq_done),
        .cfg_ignored    (cfg_ignored),
        .hs_err         (hs_err)
    );

    task automatic tick();
        @(posedge clk_48);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req"},      REQ,            1'b0);
        check({tag, "_start"},    start,          1'b0);
        check({tag, "_busy"},     busy,           1'b0);
        check({tag, "_done"},     seq_done,       1'b0);
        check({tag, "_ign"},      cfg_ignored,    1'b0);
        check({tag, "_hserr"},    hs_err,         1'b0);
        check({tag, "_freq"},     DDS_freq,       48'h0);
        check({tag, "_dfreq"},    DDS_delta_freq, 48'h0);
        check({tag, "_drate"},    DDS_delta_rate, 32'h0);
    endtask

    // Writes a configuration and answers REQ with ACK delayed by three samples.
    task automatic configure(input string tag, input logic [47:0] f, input logic [47:0] df,
                             input logic [31:0] dr, input logic [31:0] len,
                             input logic [31:0] per, input logic [15:0] cnt);
        logic [2:0] hist;
        int n;
        cfg_freq       = f;
        cfg_delta_freq = df;
        cfg_delta_rate = dr;
        cfg_pulse_len  = len;
        cfg_period     = per;
        cfg_count      = cnt;
        ACK            = 1'b0;
        cfg_wr         = 1'b1;
        tick();
        cfg_wr = 1'b0;
        check({tag, "_req_rise"}, REQ, 1'b1);
        check({tag, "_hserr_clr"}, hs_err, 1'b0);
        hist = 3'b000;
        n    = 0;
        hist = {hist[1:0], REQ};
        ACK  = hist[2];
        while (busy && n < 100) begin
            tick();
            n++;
            check({tag, "_freq_hold"}, DDS_freq, f);
            hist = {hist[1:0], REQ};
            ACK  = hist[2];
        end
        check({tag, "_hs_cycles"}, n, 6);
        check({tag, "_dfreq"}, DDS_delta_freq, df);
        check({tag, "_drate"}, DDS_delta_rate, dr);
        ACK = 1'b0;
    endtask

    // Records start rises, pulse lengths and seq_done times relative to the call.
    task automatic observe(input int ncyc);
        logic prev;
        int   last_rise;
        rise_q.delete();
        plen_q.delete();
        done_q.delete();
        prev      = start;
        last_rise = 0;
        for (int t = 1; t <= ncyc; t++) begin
            tick();
            if (start && !prev) begin
                rise_q.push_back(t);
                last_rise = t;
            end
            if (!start && prev) plen_q.push_back(t - last_rise);
            if (seq_done) done_q.push_back(t);
            prev = start;
        end
    endtask

    task automatic check_train(input string tag, input int n, input int first,
                               input int spacing, input int len, input int done_t);
        check({tag, "_nrise"}, rise_q.size(), n);
        check({tag, "_ndone"}, done_q.size(), (done_t > 0) ? 1 : 0);
        for (int i = 0; i < n; i++) begin
            check({tag, "_rise"}, (i < rise_q.size()) ? rise_q[i] : -1, first + i * spacing);
            check({tag, "_len"},  (i < plen_q.size()) ? plen_q[i] : -1, len);
        end
        if (done_t > 0) check({tag, "_done_t"}, (done_q.size() > 0) ? done_q[0] : -1, done_t);
    endtask

    task automatic stop_run();
        run = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int n_start;
        rst            = 1'b1;
        cfg_wr         = 1'b0;
        cfg_freq       = '0;
        cfg_delta_freq = '0;
        cfg_delta_rate = '0;
        cfg_pulse_len  = '0;
        cfg_period     = '0;
        cfg_count      = '0;
        run            = 1'b0;
        ACK            = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Configuration transfer
        configure("t1", 48'h0000_1000_0000, 48'h0000_0000_0100, 32'd7, 32'd100, 32'd400, 16'd3);
        check("t1_freq", DDS_freq, 48'h0000_1000_0000);
        check("t1_arm_busy", busy, 1'b0);

        // Finite burst of three
        run = 1'b1;
        observe(1300);
        check_train("t2", 3, 1, 400, 100, 901);
        check("t2_idle_busy", busy, 1'b0);
        stop_run();

        // Gap clamped to MIN_GAP
        configure("t3a", 48'h0000_2000_0000, 48'h1, 32'd1, 32'd100, 32'd101, 16'd2);
        run = 1'b1;
        observe(400);
        check_train("t3a", 2, 1, 102, 100, 203);
        stop_run();

        // Zero length behaves as one
        configure("t3b", 48'h0000_3000_0000, 48'h2, 32'd2, 32'd0, 32'd10, 16'd2);
        run = 1'b1;
        observe(60);
        check_train("t3b", 2, 1, 10, 1, 12);
        stop_run();

        // cfg_wr and run edge together: config wins, run edge is lost
        run = 1'b1;
        configure("t3c", 48'h0000_3100_0000, 48'h3, 32'd3, 32'd4, 32'd10, 16'd1);
        observe(20);
        check("t3c_no_start", rise_q.size(), 0);
        stop_run();

        // Continuous mode, ignored cfg_wr, abort mid-pulse
        configure("t5", 48'h0000_5000_0000, 48'h5, 32'd5, 32'd100, 32'd200, 16'd0);
        run     = 1'b1;
        n_start = 0;
        rise_q.delete();
        done_q.delete();
        for (int t = 1; t <= 300; t++) begin
            tick();
            if (start && rise_q.size() == 0) rise_q.push_back(t);
            if (t == 201) check("t5_2nd_rise", start, 1'b1);
            if (seq_done) done_q.push_back(t);
            if (t == 210) begin
                cfg_freq      = 48'hDEAD_BEEF_0000;
                cfg_pulse_len = 32'd3;
                cfg_wr        = 1'b1;
            end
            if (t == 211) begin
                cfg_wr = 1'b0;
                check("t5_ign_pulse", cfg_ignored, 1'b1);
                check("t5_start_kept", start, 1'b1);
            end
            if (t == 212) check("t5_ign_clear", cfg_ignored, 1'b0);
            if (t == 250) begin
                check("t5_pre_abort", start, 1'b1);
                run = 1'b0;
            end
            if (t == 251) begin
                check("t5_abort_start", start, 1'b0);
                check("t5_abort_busy", busy, 1'b0);
            end
        end
        check("t5_first_rise", (rise_q.size() > 0) ? rise_q[0] : -1, 1);
        check("t5_no_done", done_q.size(), 0);
        check("t5_freq_kept", DDS_freq, 48'h0000_5000_0000);

        // Handshake timeout
        cfg_freq = 48'h0000_4000_0000;
        ACK      = 1'b0;
        cfg_wr   = 1'b1;
        tick();
        cfg_wr = 1'b0;
        check("t4_req", REQ, 1'b1);
        repeat (1023) tick();
        check("t4_pre_err", hs_err, 1'b0);
        check("t4_pre_req", REQ, 1'b1);
        tick();
        check("t4_err", hs_err, 1'b1);
        check("t4_req_drop", REQ, 1'b0);
        check("t4_idle", busy, 1'b0);
        run = 1'b1;
        observe(10);
        check("t4_idle_no_start", rise_q.size(), 0);
        check("t4_err_sticky", hs_err, 1'b1);
        run = 1'b0;
        tick();
        configure("t4b", 48'h0000_4100_0000, 48'h4, 32'd4, 32'd10, 32'd50, 16'd0);

        // Asynchronous reset in GAP
        run = 1'b1;
        repeat (20) tick();
        check("t6_in_gap_busy", busy, 1'b1);
        check("t6_in_gap_start", start, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check_idle_outputs("t6_gap_rst");
        @(posedge clk_48);
        #1;
        rst = 1'b0;

        // Asynchronous reset in HS_HI
        cfg_freq = 48'h0000_6000_0000;
        ACK      = 1'b0;
        cfg_wr   = 1'b1;
        tick();
        cfg_wr = 1'b0;
        tick();
        check("t6_hs_req", REQ, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check_idle_outputs("t6_hs_rst");
        @(posedge clk_48);
        #1;
        rst = 1'b0;

        // run held high across configuration: no edge, no start
        configure("t6c", 48'h0000_6100_0000, 48'h6, 32'd6, 32'd5, 32'd20, 16'd0);
        observe(20);
        check("t6_level_no_start", rise_q.size(), 0);
        run = 1'b0;
        tick();
        run = 1'b1;
        tick();
        check("t6_fresh_edge", start, 1'b1);
        stop_run();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
